// File: rtl/nios_pio_arbiter.sv
// Round-robin arbiter that shares the PIO Avalon-MM slave between NUM_REQ requesters.
// One PIO transaction at a time. Read data comes back one cycle after the address phase.
module nios_pio_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2*NUM_REQ-1:0]    req_address,
    input  logic [NUM_REQ-1:0]      req_read,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [32*NUM_REQ-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]      req_waitrequest,
    output logic [31:0]             req_readdata,
    output logic [NUM_REQ-1:0]      req_readdatavalid,
    output logic [1:0]              pio_address,
    output logic                    pio_chipselect,
    output logic                    pio_write_n,
    output logic [31:0]             pio_writedata,
    input  logic [31:0]             pio_readdata,
    output logic [1:0]              dbg_state
);

    // Handshake: a requester holds address/read/write/writedata while its waitrequest
    // is high. The command is taken in the single cycle where waitrequest is low.
    // A read returns in a later cycle, marked by a one-cycle readdatavalid strobe.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic [1:0]   last_grant_q, last_grant_d;

    logic [NUM_REQ-1:0] pending;
    logic               any_pending;
    logic [1:0]         pick;
    logic               sel_read, sel_write, sel_pending;
    logic [1:0]         sel_addr;
    logic [31:0]        sel_wdata;

    assign pending     = req_read | req_write;
    assign any_pending = |pending;
    assign sel_pending = sel_read | sel_write;
    assign dbg_state   = state_q;

    // The search starts just after the last grant. This gives rotating priority.
    always_comb begin
        int idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && pending[idx]) begin
                pick  = 2'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 2'(i)) begin
                sel_read  = req_read[i];
                sel_write = req_write[i];
                sel_addr  = req_address[2*i +: 2];
                sel_wdata = req_writedata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // When read and write are both set, the access is a write. No data is returned.
                if (sel_pending && !sel_write) state_d = RDWAIT;
                else                           state_d = IDLE;
            end
            RDWAIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pio_chipselect    = 1'b0;
        pio_write_n       = 1'b1;
        pio_address       = '0;
        pio_writedata     = '0;
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        req_readdata      = '0;
        case (state_q)
            ISSUE: begin
                pio_address   = sel_addr;
                pio_writedata = sel_wdata;
                pio_write_n   = ~sel_write;
                if (sel_pending) begin
                    pio_chipselect = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (grant_q == 2'(i)) req_waitrequest[i] = 1'b0;
                end
            end
            RDWAIT: begin
                req_readdata = pio_readdata;
                for (int i = 0; i < NUM_REQ; i++)
                    if (grant_q == 2'(i)) req_readdatavalid[i] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
